// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// control and the decode-side valid/ready handshake.
interface fetch_unit_if #(
  parameter int ORDER_W = 64
);
  // instruction memory side
  logic [31:0]        imem_addr;
  logic [3:0]         imem_rmask;
  logic [31:0]        imem_rdata;
  logic               imem_resp;
  // control flow redirect
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  // decode side
  logic               dec_ready;
  logic               out_valid;
  logic [31:0]        out_inst;
  logic [31:0]        out_pc;
  logic [31:0]        out_pc_next;
  logic [ORDER_W-1:0] out_order;

  // The fetch unit drives requests and the decode output.
  modport master (
    output imem_addr, imem_rmask, out_valid, out_inst, out_pc, out_pc_next, out_order,
    input  imem_rdata, imem_resp, redirect_valid, redirect_pc, dec_ready
  );

  // Memory/decode/branch environment seen from the other side.
  modport slave (
    input  imem_addr, imem_rmask, out_valid, out_inst, out_pc, out_pc_next, out_order,
    output imem_rdata, imem_resp, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word fetch at a time to a variable
// latency memory, queues returned instructions and hands them to decode in
// program order. A redirect flushes the queue and marks any in-flight
// request as stale so its data is thrown away on return.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h1eceb000,
  parameter int          QUEUE_DEPTH = 4,   // power of two, at least 2
  parameter int          ORDER_W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = CNT_W + 1;
  localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(QUEUE_DEPTH);

  // architectural state
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_req_pc;     // PC of the request currently in flight
  logic [ORDER_W-1:0] r_order;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic               r_outst;
  logic               r_stale;
  logic [31:0]        r_inst_q [QUEUE_DEPTH];
  logic [31:0]        r_pc_q   [QUEUE_DEPTH];

  // per-cycle decisions
  logic               w_resp_ok;
  logic               w_out_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_outst_after;
  logic [CMP_W-1:0]   w_occ_after;
  logic               w_issue;
  logic [CNT_W-1:0]   w_count_nxt;

  // Handshake, push and issue decisions. The issue test counts the slot that
  // this cycle's response is about to fill, so every in-flight request always
  // has a free queue entry waiting for it.
  always_comb begin
    w_resp_ok     = 1'b0;
    w_out_valid   = 1'b0;
    w_pop         = 1'b0;
    w_push        = 1'b0;
    w_outst_after = 1'b0;
    w_occ_after   = '0;
    w_issue       = 1'b0;
    w_count_nxt   = r_count;

    w_resp_ok     = bus.imem_resp && r_outst;
    w_out_valid   = (r_count != '0) && !bus.redirect_valid && !rst;
    w_pop         = w_out_valid && bus.dec_ready;
    w_push        = w_resp_ok && !r_stale && !bus.redirect_valid && !rst;
    w_outst_after = r_outst && !bus.imem_resp;
    w_occ_after   = {1'b0, r_count} + CMP_W'(w_push) - CMP_W'(w_pop) + CMP_W'(w_outst_after);
    w_count_nxt   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    if (!rst && !bus.redirect_valid && (!r_outst || bus.imem_resp) && (w_occ_after < DEPTH_C)) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
  end

  // Memory request and decode-facing outputs; the head entry is read straight
  // from the queue so it stays stable while decode stalls.
  always_comb begin
    bus.imem_addr   = rst ? RESET_PC : r_fetch_pc;
    bus.imem_rmask  = w_issue ? 4'hF : 4'h0;
    bus.out_valid   = w_out_valid;
    bus.out_inst    = r_inst_q[r_head];
    bus.out_pc      = r_pc_q[r_head];
    bus.out_pc_next = r_pc_q[r_head] + 32'd4;
    bus.out_order   = r_order;
  end

  // Control state: reset, then redirect, then normal fetch/queue progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_order    <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_outst    <= 1'b0;
      r_stale    <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      if (r_outst && bus.imem_resp) begin
        // data arriving now belongs to the wrong path and is simply dropped
        r_outst <= 1'b0;
        r_stale <= 1'b0;
      end else if (r_outst) begin
        // wrong-path data still on its way: discard it when it lands
        r_stale <= 1'b1;
      end else begin
        r_stale <= r_stale;
      end
    end else begin
      if (w_issue) begin
        r_outst    <= 1'b1;
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end else if (w_resp_ok) begin
        r_outst <= 1'b0;
      end
      if (w_resp_ok) begin
        r_stale <= 1'b0;
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head  <= r_head + PTR_W'(1);
        r_order <= r_order + ORDER_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Queue payload storage; only written when a good response is pushed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_q[r_tail] <= bus.imem_rdata;
      r_pc_q[r_tail]   <= r_req_pc;
    end
  end

endmodule
